// File: rtl/fpu_shift_pkg.sv
// Shared types and constants for the FPU multi-cycle shift sequencer.
package fpu_shift_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Operation mode: fixed-distance shift or normalise-to-MSB
  typedef enum logic {
    MODE_SHIFT = 1'b0,
    MODE_NORM  = 1'b1
  } mode_e;

  // Shift direction encoding
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_step.sv
// Combinational one-bit logical shifter (zero fill) used once per SHIFT cycle.
module shift_step
  import fpu_shift_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  dir,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] step_c
);

  // Single-position shift in the requested direction
  always_comb begin
    step_c = '0;
    if (dir == DIR_RIGHT) begin
      step_c = {1'b0, data_i[DATA_WIDTH-1:1]};
    end else begin
      step_c = {data_i[DATA_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: left/right shift with sticky, or normalise.
// One operation in flight; one bit of shift per cycle.
module shift_sequencer
  import fpu_shift_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned AMT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [AMT_WIDTH-1:0]  in_amt,
  input  logic                  in_dir,
  input  logic                  in_norm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [AMT_WIDTH-1:0]  out_count,
  output logic                  out_sticky
);

  localparam logic [AMT_WIDTH-1:0] AMT_MAX = AMT_WIDTH'(DATA_WIDTH);

  state_e                  state_q,     state_d;
  mode_e                   mode_q,      mode_d;
  logic                    dir_q,       dir_d;
  logic [DATA_WIDTH-1:0]   data_q,      data_d;
  logic [AMT_WIDTH-1:0]    sat_q,       sat_d;
  logic [AMT_WIDTH-1:0]    count_q,     count_d;
  logic                    sticky_q,    sticky_d;
  logic                    out_valid_q, out_valid_d;
  logic                    in_ready_q,  in_ready_d;

  logic [AMT_WIDTH-1:0]    sat_amt_c;
  logic [DATA_WIDTH-1:0]   step_c;

  // Shift distance clamped to the operand width
  always_comb begin
    sat_amt_c = in_amt;
    if (in_amt > AMT_MAX) begin
      sat_amt_c = AMT_MAX;
    end
  end

  shift_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .dir    (dir_q),
    .data_i (data_q),
    .step_c (step_c)
  );

  // Next-state, datapath and handshake flag computation
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    dir_d     = dir_q;
    data_d    = data_q;
    sat_d     = sat_q;
    count_d   = count_q;
    sticky_d  = sticky_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d   = in_data;
          mode_d   = in_norm ? MODE_NORM : MODE_SHIFT;
          dir_d    = in_norm ? DIR_LEFT : in_dir;
          sat_d    = sat_amt_c;
          count_d  = '0;
          sticky_d = 1'b0;
          if (in_norm) begin
            if (in_data == '0) begin
              // Zero cannot be normalised: report a full-width distance
              count_d = AMT_MAX;
              state_d = ST_DONE;
            end else if (in_data[DATA_WIDTH-1]) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_SHIFT;
            end
          end else if (sat_amt_c == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        data_d  = step_c;
        count_d = count_q + AMT_WIDTH'(1);
        if (dir_q == DIR_RIGHT) begin
          sticky_d = sticky_q | data_q[0];
        end
        if (mode_q == MODE_NORM) begin
          if (step_c[DATA_WIDTH-1]) begin
            state_d = ST_DONE;
          end
        end else if (count_d == sat_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    out_valid_d = (state_d == ST_DONE);
    in_ready_d  = (state_d == ST_IDLE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_SHIFT;
      dir_q       <= DIR_LEFT;
      data_q      <= '0;
      sat_q       <= '0;
      count_q     <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      dir_q       <= dir_d;
      data_q      <= data_d;
      sat_q       <= sat_d;
      count_q     <= count_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = data_q;
  assign out_count  = count_q;
  assign out_sticky = sticky_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer.
module tb_shift_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_amt;
  logic          in_dir;
  logic          in_norm;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_count;
  logic          out_sticky;

  int checks   = 0;
  int failures = 0;
  int lat;

  shift_sequencer #(.DATA_WIDTH(DW), .AMT_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_dir     (in_dir),
    .in_norm    (in_norm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_sticky (out_sticky)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for out_valid; lat = cycles after accept
  task automatic issue(input logic [DW-1:0] d, input logic [AW-1:0] a,
                       input logic dir, input logic norm, output int l);
    check("ready_before_issue", 64'(in_ready), 64'd1);
    in_data  = d;
    in_amt   = a;
    in_dir   = dir;
    in_norm  = norm;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    l = 1;
    while (!out_valid && l < 100) begin
      step();
      l++;
    end
  endtask

  task automatic expect_result(input string tag, input logic [DW-1:0] d, input logic [AW-1:0] c,
                               input logic s, input int l_obs, input int l_exp);
    check({tag, "_valid"},  64'(out_valid),  64'd1);
    check({tag, "_data"},   64'(out_data),   64'(d));
    check({tag, "_count"},  64'(out_count),  64'(c));
    check({tag, "_sticky"}, 64'(out_sticky), 64'(s));
    check({tag, "_lat"},    64'(l_obs),      64'(l_exp));
  endtask

  task automatic retire(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_retire_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_retire_ready"}, 64'(in_ready),  64'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_dir    = 1'b0;
    in_norm   = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_in_ready",   64'(in_ready),   64'd1);
    check("rst_out_valid",  64'(out_valid),  64'd0);
    check("rst_out_data",   64'(out_data),   64'd0);
    check("rst_out_count",  64'(out_count),  64'd0);
    check("rst_out_sticky", 64'(out_sticky), 64'd0);
    rst_n = 1'b1;
    step();

    issue(32'h0000_00F0, 6'd4, 1'b0, 1'b0, lat);
    expect_result("left4", 32'h0000_0F00, 6'd4, 1'b0, lat, 5);
    retire("left4");

    issue(32'h0000_00F3, 6'd4, 1'b1, 1'b0, lat);
    expect_result("right4_st", 32'h0000_000F, 6'd4, 1'b1, lat, 5);
    retire("right4_st");

    issue(32'h0000_00F0, 6'd4, 1'b1, 1'b0, lat);
    expect_result("right4_ns", 32'h0000_000F, 6'd4, 1'b0, lat, 5);
    retire("right4_ns");

    issue(32'h0001_0000, 6'd0, 1'b0, 1'b1, lat);
    expect_result("norm", 32'h8000_0000, 6'd15, 1'b0, lat, 16);
    retire("norm");

    issue(32'h0000_0000, 6'd7, 1'b1, 1'b1, lat);
    expect_result("norm_zero", 32'h0000_0000, 6'd32, 1'b0, lat, 1);
    retire("norm_zero");

    issue(32'h8000_0000, 6'd3, 1'b0, 1'b1, lat);
    expect_result("norm_msb", 32'h8000_0000, 6'd0, 1'b0, lat, 1);
    retire("norm_msb");

    issue(32'h0000_A5A5, 6'd0, 1'b1, 1'b0, lat);
    expect_result("amt0", 32'h0000_A5A5, 6'd0, 1'b0, lat, 1);
    retire("amt0");

    issue(32'h0000_0001, 6'd40, 1'b1, 1'b0, lat);
    expect_result("right40", 32'h0000_0000, 6'd32, 1'b1, lat, 33);
    retire("right40");

    issue(32'hFFFF_FFFF, 6'd32, 1'b0, 1'b0, lat);
    expect_result("left32", 32'h0000_0000, 6'd32, 1'b0, lat, 33);
    retire("left32");

    // Backpressure: result held, new requests ignored while in DONE
    issue(32'h0000_0001, 6'd1, 1'b0, 1'b0, lat);
    expect_result("bp", 32'h0000_0002, 6'd1, 1'b0, lat, 2);
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    in_amt   = 6'd3;
    in_dir   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid",  64'(out_valid), 64'd1);
      check("bp_ready",  64'(in_ready),  64'd0);
      check("bp_data",   64'(out_data),  64'h2);
      check("bp_count",  64'(out_count), 64'd1);
    end
    in_valid = 1'b0;
    retire("bp");
    step();
    check("bp_no_ghost", 64'(out_valid), 64'd0);

    // Reset during SHIFT discards the operation
    in_data  = 32'h0000_FF00;
    in_amt   = 6'd8;
    in_dir   = 1'b1;
    in_norm  = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("mid_count_pre", 64'(out_count), 64'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_valid",  64'(out_valid),  64'd0);
    check("mid_rst_ready",  64'(in_ready),   64'd1);
    check("mid_rst_data",   64'(out_data),   64'd0);
    check("mid_rst_count",  64'(out_count),  64'd0);
    check("mid_rst_sticky", 64'(out_sticky), 64'd0);
    step();
    check("mid_rst_idle", 64'(out_valid), 64'd0);

    issue(32'h0000_0003, 6'd2, 1'b0, 1'b0, lat);
    expect_result("post_rst", 32'h0000_000C, 6'd2, 1'b0, lat, 3);
    retire("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
